// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES block types, packer FSM states and padding helper
package aes_pkg;

  localparam int AES_BLOCK_BYTES = 16;
  localparam int AES_BLOCK_BITS  = 128;

  typedef logic [AES_BLOCK_BITS-1:0] aes_block_t;

  typedef struct packed {
    logic       last;
    aes_block_t data;
  } aes_entry_t;

  typedef enum logic {ST_FILL, ST_PAD} pack_state_e;

  // asm_q holds the message bytes in its low lanes; they move to the top and the
  // low pad_n lanes take the fill byte. pad_n == 16 shifts every stale byte out.
  function automatic aes_block_t pad_block(input logic [119:0] asm_q,
                                           input logic [4:0]   pad_n,
                                           input logic [7:0]   fill);
    aes_block_t blk;
    blk = {8'h00, asm_q} << {pad_n, 3'b000};
    for (int i = 0; i < AES_BLOCK_BYTES; i++) begin
      if (i < int'(pad_n)) blk[8*i +: 8] = fill;
    end
    return blk;
  endfunction

endpackage

// File: rtl/aes_block_packer_if.sv
// rtl/aes_block_packer_if.sv - byte-in / block-out handshake bundle of the packer
interface aes_block_packer_if;

  logic                  in_valid;
  logic                  in_ready;
  logic [7:0]            in_data;
  logic                  in_last;
  logic                  out_valid;
  logic                  out_ready;
  aes_pkg::aes_block_t   out_data;
  logic                  out_last;
  logic [31:0]           blocks_out;

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_last, blocks_out
  );

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_last, blocks_out
  );

endinterface

// File: rtl/aes_block_fifo.sv
// rtl/aes_block_fifo.sv - synchronous FIFO of {last, data} block entries
module aes_block_fifo
  import aes_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  aes_entry_t push_entry,
  input  logic       pop,
  output aes_entry_t head,
  output logic       full,
  output logic       empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  aes_entry_t      mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic            do_push;
  logic            do_pop;

  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  // Head reads as zero while empty so the outputs are clean out of reset.
  assign head    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_entry;
  end

endmodule

// File: rtl/aes_block_packer.sv
// rtl/aes_block_packer.sv - packs a byte stream into 128-bit AES blocks with PKCS#7 padding
module aes_block_packer
  import aes_pkg::*;
#(
  parameter bit PAD_ENABLE = 1'b1,
  parameter int OUT_DEPTH  = 2
) (
  input  logic               clk,
  input  logic               rst,
  aes_block_packer_if.slave  bus
);

  pack_state_e  state, state_d;
  logic [3:0]   byte_cnt, byte_cnt_d;
  logic [119:0] asm_q, asm_d;
  logic [4:0]   pad_n, pad_n_d;
  logic [31:0]  blocks_out;

  logic         in_ready;
  logic         accept;
  logic         push;
  aes_entry_t   push_entry;
  aes_entry_t   head;
  logic         q_full;
  logic         q_empty;
  logic [7:0]   fill_byte;

  // Registered q_full only: the byte that would complete a block waits for space.
  assign in_ready  = (state == ST_FILL) && !(byte_cnt == 4'd15 && q_full);
  assign accept    = bus.in_valid && in_ready;
  assign fill_byte = PAD_ENABLE ? {3'b000, pad_n} : 8'h00;

  always_comb begin
    state_d    = state;
    byte_cnt_d = byte_cnt;
    asm_d      = asm_q;
    pad_n_d    = pad_n;
    push       = 1'b0;
    push_entry = '0;
    case (state)
      ST_FILL: begin
        if (accept) begin
          if (byte_cnt == 4'd15) begin
            push            = 1'b1;
            push_entry.data = {asm_q, bus.in_data};
            push_entry.last = bus.in_last && !PAD_ENABLE;
            byte_cnt_d      = 4'd0;
            if (bus.in_last && PAD_ENABLE) begin
              state_d = ST_PAD;
              pad_n_d = 5'd16;
            end
          end else begin
            asm_d      = {asm_q[111:0], bus.in_data};
            byte_cnt_d = byte_cnt + 4'd1;
            if (bus.in_last) begin
              state_d = ST_PAD;
              pad_n_d = 5'd15 - {1'b0, byte_cnt};
            end
          end
        end
      end
      ST_PAD: begin
        if (!q_full) begin
          push            = 1'b1;
          push_entry.data = pad_block(asm_q, pad_n, fill_byte);
          push_entry.last = 1'b1;
          byte_cnt_d      = 4'd0;
          state_d         = ST_FILL;
        end
      end
      default: state_d = ST_FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_FILL;
      byte_cnt   <= 4'd0;
      asm_q      <= '0;
      pad_n      <= 5'd0;
      blocks_out <= 32'd0;
    end else begin
      state    <= state_d;
      byte_cnt <= byte_cnt_d;
      asm_q    <= asm_d;
      pad_n    <= pad_n_d;
      if (!q_empty && bus.out_ready) blocks_out <= blocks_out + 32'd1;
    end
  end

  aes_block_fifo #(
    .DEPTH (OUT_DEPTH)
  ) u_out_q (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_entry (push_entry),
    .pop        (bus.out_ready),
    .head       (head),
    .full       (q_full),
    .empty      (q_empty)
  );

  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = !q_empty;
  assign bus.out_data   = head.data;
  assign bus.out_last   = head.last;
  assign bus.blocks_out = blocks_out;

endmodule

// File: tb/tb_aes_block_packer.sv
// tb/tb_aes_block_packer.sv - bench for aes_block_packer, padded and zero-fill instances
module tb_aes_block_packer;
  import aes_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  aes_block_packer_if a_if ();
  aes_block_packer_if b_if ();

  aes_block_packer #(.PAD_ENABLE(1'b1), .OUT_DEPTH(2)) u_pad (
    .clk (clk), .rst (rst), .bus (a_if.slave)
  );
  aes_block_packer #(.PAD_ENABLE(1'b0), .OUT_DEPTH(2)) u_zero (
    .clk (clk), .rst (rst), .bus (b_if.slave)
  );

  int checks   = 0;
  int failures = 0;
  bit rand_rdy = 1'b0;

  logic [128:0] exp_a[$], exp_b[$], obs_a[$], obs_b[$];
  logic [7:0]   pend_a[$], pend_b[$];
  int ci_a = 0, ci_b = 0, base_a = 0, base_b = 0;

  always @(negedge clk) begin
    if (!rst && a_if.out_valid && a_if.out_ready) obs_a.push_back({a_if.out_last, a_if.out_data});
    if (!rst && b_if.out_valid && b_if.out_ready) obs_b.push_back({b_if.out_last, b_if.out_data});
  end

  task automatic chk(input string tag, input logic [159:0] o, input logic [159:0] e);
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_rdy) begin
      a_if.out_ready = ($urandom_range(0, 3) != 0);
      b_if.out_ready = ($urandom_range(0, 3) != 0);
    end
  endtask

  task automatic drive(input bit sel, input bit v, input logic [7:0] d, input bit l);
    if (sel) begin
      b_if.in_valid = v; b_if.in_data = d; b_if.in_last = l;
    end else begin
      a_if.in_valid = v; a_if.in_data = d; a_if.in_last = l;
    end
  endtask

  // Reference: bytes of a message are collected; 16 non-final bytes form a block,
  // the final byte triggers padding (PKCS#7 on A, zero-fill on B) and chunking.
  task automatic model_byte(input bit sel, input logic [7:0] d, input bit l);
    logic [7:0]   p[$];
    logic [127:0] blk;
    int           n;
    if (sel) p = pend_b; else p = pend_a;
    p.push_back(d);
    if (l || p.size() == 16) begin
      if (l) begin
        n = 16 - (p.size() % 16);
        if (!sel) begin
          for (int k = 0; k < n; k++) p.push_back(8'(n));
        end else if (n != 16) begin
          for (int k = 0; k < n; k++) p.push_back(8'h00);
        end
      end
      for (int k = 0; k < p.size(); k += 16) begin
        for (int j = 0; j < 16; j++) blk[127-8*j -: 8] = p[k+j];
        if (sel) exp_b.push_back({l && (k + 16 >= p.size()), blk});
        else     exp_a.push_back({l && (k + 16 >= p.size()), blk});
      end
      p.delete();
    end
    if (sel) pend_b = p; else pend_a = p;
  endtask

  task automatic put(input bit sel, input logic [7:0] d, input bit l);
    bit done = 1'b0;
    drive(sel, 1'b1, d, l);
    for (int w = 0; w < 300 && !done; w++) begin
      if (sel ? b_if.in_ready : a_if.in_ready) done = 1'b1;
      tick();
    end
    drive(sel, 1'b0, 8'h00, 1'b0);
    if (!done) chk("accept_wait", done, 1'b1);
    else model_byte(sel, d, l);
  endtask

  task automatic drain(input bit sel);
    int w = 0;
    if (!sel) begin
      while (obs_a.size() < exp_a.size() && w < 600) begin tick(); w++; end
      chk("drain_count_a", obs_a.size(), exp_a.size());
      for (int i = ci_a; i < exp_a.size() && i < obs_a.size(); i++) chk("block_a", obs_a[i], exp_a[i]);
      ci_a = exp_a.size();
      chk("blocks_out_a", a_if.blocks_out, exp_a.size() - base_a);
    end else begin
      while (obs_b.size() < exp_b.size() && w < 600) begin tick(); w++; end
      chk("drain_count_b", obs_b.size(), exp_b.size());
      for (int i = ci_b; i < exp_b.size() && i < obs_b.size(); i++) chk("block_b", obs_b[i], exp_b[i]);
      ci_b = exp_b.size();
      chk("blocks_out_b", b_if.blocks_out, exp_b.size() - base_b);
    end
  endtask

  initial begin
    int          idx;
    bit          rdy;
    logic [7:0]  msg5 [5];
    logic [128:0] ent;
    rst = 1'b1;
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    drive(1'b1, 1'b0, 8'h00, 1'b0);
    a_if.out_ready = 1'b1;
    b_if.out_ready = 1'b1;
    tick(); tick();
    chk("rst_in_ready", a_if.in_ready, 1'b1);
    chk("rst_out_valid", a_if.out_valid, 1'b0);
    chk("rst_out_data", a_if.out_data, 128'h0);
    chk("rst_out_last", a_if.out_last, 1'b0);
    chk("rst_blocks_out", a_if.blocks_out, 32'h0);
    chk("rst_b_in_ready", b_if.in_ready, 1'b1);
    chk("rst_b_out_valid", b_if.out_valid, 1'b0);
    rst = 1'b0;
    tick();

    // Full block, first byte lands in the top lane.
    for (int i = 0; i < 16; i++) put(1'b0, 8'(i), 1'b0);
    chk("full_valid_t1", a_if.out_valid, 1'b1);
    chk("full_data", a_if.out_data, 128'h000102030405060708090A0B0C0D0E0F);
    chk("full_last", a_if.out_last, 1'b0);
    tick();
    chk("full_blocks_out", a_if.blocks_out, 32'd1);
    drain(1'b0);

    // Short message: PAD cycle, so block visible at t+2.
    msg5 = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
    for (int i = 0; i < 5; i++) put(1'b0, msg5[i], i == 4);
    chk("short_valid_t1", a_if.out_valid, 1'b0);
    tick();
    chk("short_valid_t2", a_if.out_valid, 1'b1);
    chk("short_data", a_if.out_data, 128'hAABBCCDDEE0B0B0B0B0B0B0B0B0B0B0B);
    chk("short_last", a_if.out_last, 1'b1);
    drain(1'b0);

    // Exact multiple of 16 gets a whole extra pad block.
    for (int i = 0; i < 16; i++) put(1'b0, 8'(i), i == 15);
    drain(1'b0);
    ent = obs_a[obs_a.size()-2];
    chk("exact_blk1", ent, {1'b0, 128'h000102030405060708090A0B0C0D0E0F});
    ent = obs_a[obs_a.size()-1];
    chk("exact_blk2", ent, {1'b1, {16{8'h10}}});

    // Backpressure: 47 bytes accepted, then the block-completing byte stalls.
    a_if.out_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 60; c++) begin
      if (idx < 48) drive(1'b0, 1'b1, 8'(idx), 1'b0);
      rdy = a_if.in_ready;
      tick();
      if (rdy && idx < 48) begin model_byte(1'b0, 8'(idx), 1'b0); idx++; end
    end
    chk("bp_accepted", idx, 47);
    chk("bp_in_ready", a_if.in_ready, 1'b0);
    chk("bp_out_valid", a_if.out_valid, 1'b1);
    a_if.out_ready = 1'b1;
    for (int c = 0; c < 10 && idx < 48; c++) begin
      rdy = a_if.in_ready;
      tick();
      if (rdy) begin model_byte(1'b0, 8'(idx), 1'b0); idx++; end
    end
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    chk("bp_last_byte", idx, 48);
    drain(1'b0);

    // Zero-fill instance.
    put(1'b1, 8'h11, 1'b0); put(1'b1, 8'h22, 1'b0); put(1'b1, 8'h33, 1'b1);
    drain(1'b1);
    ent = obs_b[obs_b.size()-1];
    chk("zero_fill_blk", ent, {1'b1, 128'h11223300000000000000000000000000});
    for (int i = 0; i < 16; i++) put(1'b1, 8'(i), i == 15);
    drain(1'b1);
    chk("zero_no_extra", obs_b.size(), 2);
    ent = obs_b[obs_b.size()-1];
    chk("zero_exact_blk", ent, {1'b1, 128'h000102030405060708090A0B0C0D0E0F});

    // Reset mid-block discards the partial bytes.
    for (int i = 0; i < 7; i++) put(1'b0, 8'($urandom_range(0, 255)), 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    pend_a.delete(); pend_b.delete();
    base_a = exp_a.size(); base_b = exp_b.size();
    tick();
    chk("mid_rst_blocks_out", a_if.blocks_out, 32'd0);
    chk("mid_rst_in_ready", a_if.in_ready, 1'b1);
    chk("mid_rst_out_valid", a_if.out_valid, 1'b0);
    for (int i = 0; i < 16; i++) put(1'b0, 8'(i), 1'b0);
    drain(1'b0);
    ent = obs_a[obs_a.size()-1];
    chk("mid_rst_blk", ent, {1'b0, 128'h000102030405060708090A0B0C0D0E0F});

    // Random messages with random gaps and random downstream stalls.
    rand_rdy = 1'b1;
    for (int m = 0; m < 14; m++) begin
      bit sel;
      int len;
      sel = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 40);
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 3) == 0) tick();
        put(sel, 8'($urandom_range(0, 255)), i == len - 1);
      end
    end
    drain(1'b0);
    drain(1'b1);
    rand_rdy = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/aes_block_packer.md
# aes_block_packer

Byte-stream front end for the AES `ENCRYPT`/`DECRYPT` pipelines. It accepts one 8-bit byte per cycle over a valid/ready handshake and packs each 16 bytes into a 128-bit block, with the first byte in bits [127:120]. On end of message it applies PKCS#7 padding. Completed blocks are buffered in a small output queue and presented on `out_valid`/`out_data`. The pipeline's `validIn`/`in` connect here with `out_ready` tied high, or the ports are driven through a downstream throttle.

## Interface
- `PAD_ENABLE`, default 1: 1 selects PKCS#7 padding; 0 zero-fills a partial final block and adds no extra block.
- `OUT_DEPTH`, default 2: output queue depth in blocks, ≥1.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset; one clock, synchronous, active-high.
- `in_valid`  in  1  byte offered.
- `in_ready`  out  1  byte accepted when `in_valid && in_ready`.
- `in_data`  in  8  byte.
- `in_last`  in  1  marks the final byte of a message; sampled with the accepted byte.
- `out_valid`  out  1  queue head valid.
- `out_ready`  in  1  block consumed when `out_valid && out_ready`.
- `out_data`  out  128  queue head block.
- `out_last`  out  1  head block ends a message.
- `blocks_out`  out  32  count of consumed blocks; wraps modulo 2^32.

## Operation
- State: `byte_cnt` (4 bits, 0..15), assembly register `asm[119:0]`, and FSM {FILL, PAD}.
- Queue: synchronous FIFO of OUT_DEPTH entries, each {last, data[127:0]}.
  - A push and a pop may occur in the same cycle.
  - `q_full` is the registered occupancy == OUT_DEPTH.
- **FILL state**
  - `in_ready = !(byte_cnt==15 && q_full)`. There is no combinational path from `out_ready`.
  - **Accept with byte_cnt < 15, no `in_last`:** shift the byte into `asm`, then `byte_cnt++`.
  - **Accept with byte_cnt == 15:**
    - Push `{asm, in_data}`; `byte_cnt` = 0.
    - If `in_last` and PAD_ENABLE: push with last = 0, go to PAD with `pad_n` = 16.
    - Otherwise push with last = `in_last`.
  - **Accept with byte_cnt < 15 and `in_last`:**
    - Shift the byte in.
    - If PAD_ENABLE: go to PAD with `pad_n` = 15 − byte_cnt.
    - Otherwise go to PAD with fill byte 0x00.
- **PAD state**
  - `in_ready` = 0.
  - Build the block as `asm` bytes followed by `pad_n` copies of byte value `pad_n`. With PAD_ENABLE = 0, the fill byte is 0x00 instead.
  - Push with last = 1 when the queue has space (`!q_full`). Then clear `byte_cnt` and return to FILL.
  - If `q_full`, remain in PAD.
- **Output counter:** `blocks_out` increments on each `out_valid && out_ready`.
- **Simultaneous push and pop when the queue is full:** the push is not allowed. `in_ready`/PAD use the registered `q_full`, so the push stalls one cycle.
- **`in_valid` with `in_ready` low:** no state change; the upstream holds the byte.
- **Reset, including mid-block or in PAD:**
  - `byte_cnt` = 0, FSM = FILL, queue emptied, `blocks_out` = 0.
  - Partially packed bytes are discarded.

## Timing
- Reset values: `in_ready`=1, `out_valid`=0, `out_data`=0, `out_last`=0, `blocks_out`=0.
- Latency:
  - A block completed by a byte accepted at cycle t has `out_valid` high from t+1 when the queue was empty.
  - A padded block whose last byte is accepted at t has `out_valid` from t+2.
- Throughput:
  - One byte per cycle.
  - One block per 16 cycles with no bubbles between blocks of a message.
  - One PAD cycle per message end.
- `out_data`/`out_last` hold stable while `out_valid && !out_ready`.

## Structure
- Shared package `aes_pkg`:
  - `AES_BLOCK_BYTES` = 16 and `AES_BLOCK_BITS` = 128.
  - The `aes_block_t` typedef and the FSM state enum.
- One sub-module: `aes_block_fifo`, a parameterised synchronous block FIFO carrying {last, data} with full/empty flags. The packer instantiates it for the output queue.

## Test plan
- **Full block:** bytes 0x00..0x0F, no last, `out_ready`=1 → one cycle after byte 16, `out_data` = 0x000102030405060708090A0B0C0D0E0F, `out_last`=0, `blocks_out`=1.
- **Short message:** 5 bytes 0xAA,0xBB,0xCC,0xDD,0xEE with `in_last` on 0xEE → one block 0xAABBCCDDEE followed by eleven 0x0B bytes, `out_last`=1, `out_valid` at t+2.
- **Exact multiple of 16:** 16 bytes 0x00..0x0F with last on 0x0F → block 1 as above with last=0, then a block of sixteen 0x10 bytes with last=1.
- **Backpressure:** OUT_DEPTH=2, `out_ready`=0, 48 bytes offered continuously → `in_ready` drops with byte_cnt=15 of block 3, after 47 bytes accepted. Raise `out_ready` → the 48th byte is accepted, and 3 blocks drain in order with `blocks_out`=3.
- **PAD_ENABLE=0:** 3 bytes 0x11,0x22,0x33 with last → block 0x112233 followed by thirteen 0x00 bytes, last=1. A 16-byte message produces no extra block.
- **Reset mid-operation:** pulse `rst` after 7 bytes, then send 0x00..0x0F → one block equal to 0x00..0x0F only, `blocks_out`=1.
